// File: rtl/bomberman_pkg.sv
// Shared types and constants for the bomberman player logic: FSM encoding,
// sprite corner indices, walkable tile id and playfield bounds.
package bomberman_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        MOVE,
        DONE
    } state_t;

    // Bit 0 selects the right edge, bit 1 the bottom edge of the sprite.
    localparam logic [1:0] CORNER_TL = 2'd0;
    localparam logic [1:0] CORNER_TR = 2'd1;
    localparam logic [1:0] CORNER_BL = 2'd2;
    localparam logic [1:0] CORNER_BR = 2'd3;

    localparam logic [3:0] EMPTY_TILE = 4'd0;

    localparam int PF_MIN_X = 72;
    localparam int PF_MAX_X = 232;
    localparam int PF_MIN_Y = 32;
    localparam int PF_MAX_Y = 192;

endpackage

// File: rtl/inv_timer.sv
// Invincibility countdown: load restarts the count, it then decrements every
// clock down to zero; active is high while the count is nonzero.
module inv_timer #(
    parameter int INV_CYCLES = 100000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic load,
    output logic active
);

    localparam int CNT_W = $clog2(INV_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(INV_CYCLES);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = LOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign active = (count_q != '0);

endmodule

// File: rtl/player_engine.sv
// Player movement/damage engine: each step probes the four sprite corners
// against the tile map, then moves per axis and applies explosion damage.
module player_engine
    import bomberman_pkg::*;
#(
    parameter int         COORD_W    = 9,
    parameter int         START_X    = 72,
    parameter int         START_Y    = 112,
    parameter int         MIN_X      = PF_MIN_X,
    parameter int         MAX_X      = PF_MAX_X,
    parameter int         MIN_Y      = PF_MIN_Y,
    parameter int         MAX_Y      = PF_MAX_Y,
    parameter logic [4:0] SPEED      = 5'd2,
    parameter int         SPRITE     = 16,
    parameter int         LIVES_MAX  = 3,
    parameter int         INV_CYCLES = 100000000,
    parameter logic [3:0] EMPTY_TILE = bomberman_pkg::EMPTY_TILE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               player_reset,
    input  logic               step,
    input  logic               xmov,
    input  logic               xdir,
    input  logic               ymov,
    input  logic               ydir,
    output logic [COORD_W-1:0] probe_x,
    output logic [COORD_W-1:0] probe_y,
    output logic               probe_valid,
    input  logic [3:0]         probe_tile_id,
    input  logic               probe_explosion,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [1:0]         lives,
    output logic               is_invincible,
    output logic               dead,
    output logic               busy,
    output logic               done
);

    localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(SPEED);
    localparam logic [COORD_W-1:0] EDGE_OFS  = COORD_W'(SPRITE - 1);
    localparam logic [COORD_W-1:0] X_INC_LIM = COORD_W'(MAX_X - int'(SPEED));
    localparam logic [COORD_W-1:0] X_DEC_LIM = COORD_W'(MIN_X + int'(SPEED));
    localparam logic [COORD_W-1:0] Y_INC_LIM = COORD_W'(MAX_Y - int'(SPEED));
    localparam logic [COORD_W-1:0] Y_DEC_LIM = COORD_W'(MIN_Y + int'(SPEED));
    localparam logic [COORD_W-1:0] START_XC  = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_YC  = COORD_W'(START_Y);
    localparam logic [1:0]         LIVES_C   = 2'(LIVES_MAX);

    function automatic logic [COORD_W-1:0] corner_coord(input logic [COORD_W-1:0] base,
                                                        input logic far_edge);
        return far_edge ? base + EDGE_OFS : base;
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         corner_q, corner_d, next_corner;
    logic [3:0]         empty_q, empty_d;
    logic               hit_q, hit_d;
    logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]         lives_q, lives_d;
    logic               probe_valid_q, probe_valid_d;
    logic [COORD_W-1:0] probe_x_q, probe_x_d, probe_y_q, probe_y_d;
    logic               timer_load;

    inv_timer #(
        .INV_CYCLES(INV_CYCLES)
    ) u_inv_timer (
        .clock (clock),
        .reset (reset),
        .clear (player_reset),
        .load  (timer_load),
        .active(is_invincible)
    );

    always_comb begin
        state_d       = state_q;
        corner_d      = corner_q;
        empty_d       = empty_q;
        hit_d         = hit_q;
        pos_x_d       = pos_x_q;
        pos_y_d       = pos_y_q;
        lives_d       = lives_q;
        probe_valid_d = 1'b0;
        probe_x_d     = probe_x_q;
        probe_y_d     = probe_y_q;
        timer_load    = 1'b0;
        next_corner   = corner_q + 2'd1;

        if (player_reset) begin
            state_d  = IDLE;
            corner_d = CORNER_TL;
            empty_d  = '0;
            hit_d    = 1'b0;
            pos_x_d  = START_XC;
            pos_y_d  = START_YC;
            lives_d  = LIVES_C;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (step && !dead) begin
                        state_d       = ISSUE;
                        corner_d      = CORNER_TL;
                        empty_d       = '0;
                        hit_d         = 1'b0;
                        probe_valid_d = 1'b1;
                        probe_x_d     = pos_x_q;
                        probe_y_d     = pos_y_q;
                    end
                end
                ISSUE: state_d = WAIT;
                WAIT: begin
                    empty_d[corner_q] = (probe_tile_id == EMPTY_TILE);
                    hit_d             = hit_q | probe_explosion;
                    if (corner_q == CORNER_BR) begin
                        state_d = MOVE;
                    end else begin
                        // The next probe is registered here so it appears one cycle after WAIT.
                        state_d       = ISSUE;
                        corner_d      = next_corner;
                        probe_valid_d = 1'b1;
                        probe_x_d     = corner_coord(pos_x_q, next_corner[0]);
                        probe_y_d     = corner_coord(pos_y_q, next_corner[1]);
                    end
                end
                MOVE: begin
                    state_d = DONE;
                    if (!dead && xmov) begin
                        if (xdir) begin
                            if (empty_q[CORNER_TR] && empty_q[CORNER_BR] && pos_x_q <= X_INC_LIM)
                                pos_x_d = pos_x_q + STEP_C;
                        end else if (empty_q[CORNER_TL] && empty_q[CORNER_BL] && pos_x_q >= X_DEC_LIM) begin
                            pos_x_d = pos_x_q - STEP_C;
                        end
                    end
                    if (!dead && ymov) begin
                        if (ydir) begin
                            if (empty_q[CORNER_BL] && empty_q[CORNER_BR] && pos_y_q <= Y_INC_LIM)
                                pos_y_d = pos_y_q + STEP_C;
                        end else if (empty_q[CORNER_TL] && empty_q[CORNER_TR] && pos_y_q >= Y_DEC_LIM) begin
                            pos_y_d = pos_y_q - STEP_C;
                        end
                    end
                    if (hit_q && !is_invincible) begin
                        timer_load = 1'b1;
                        if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    hit_d   = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            corner_q      <= CORNER_TL;
            empty_q       <= '0;
            hit_q         <= 1'b0;
            pos_x_q       <= START_XC;
            pos_y_q       <= START_YC;
            lives_q       <= LIVES_C;
            probe_valid_q <= 1'b0;
            probe_x_q     <= '0;
            probe_y_q     <= '0;
        end else begin
            state_q       <= state_d;
            corner_q      <= corner_d;
            empty_q       <= empty_d;
            hit_q         <= hit_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            lives_q       <= lives_d;
            probe_valid_q <= probe_valid_d;
            probe_x_q     <= probe_x_d;
            probe_y_q     <= probe_y_d;
        end
    end

    assign probe_valid = probe_valid_q;
    assign probe_x     = probe_x_q;
    assign probe_y     = probe_y_q;
    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign lives       = lives_q;
    assign dead        = (lives_q == 2'd0);
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

endmodule

// File: tb/tb_player_engine.sv
// Directed bench for player_engine: a tile/explosion map answers probes by
// sprite corner, and each step's timing and outcome is compared to hand values.
module tb_player_engine;

    logic       clock = 1'b0;
    logic       reset, player_reset, step, xmov, xdir, ymov, ydir;
    logic [8:0] probe_x, probe_y, pos_x, pos_y;
    logic       probe_valid, probe_explosion;
    logic [3:0] probe_tile_id;
    logic [1:0] lives;
    logic       is_invincible, dead, busy, done;

    // Second instance spawned at x=73 for the odd-coordinate left bound.
    logic       step73, xmov73, xdir73, ymov73, ydir73, expl73;
    logic [3:0] tile73;
    logic [8:0] probe_x73, probe_y73, pos_x73, pos_y73;
    logic       probe_valid73, inv73, dead73, busy73, done73;
    logic [1:0] lives73;

    logic [15:0] tile_map;
    logic [3:0]  expl_map;
    logic [1:0]  pcorner;

    int checks   = 0;
    int failures = 0;

    logic [15:0] pv_mask;
    int          done_n, done_cnt, pv_cnt, busy_cnt;
    logic        busy1;
    logic [8:0]  px9, px10, py10, tr_px, tr_py, br_px, br_py;

    always #5 clock = ~clock;

    player_engine #(.INV_CYCLES(100)) u_dut (
        .clock(clock), .reset(reset), .player_reset(player_reset), .step(step),
        .xmov(xmov), .xdir(xdir), .ymov(ymov), .ydir(ydir),
        .probe_x(probe_x), .probe_y(probe_y), .probe_valid(probe_valid),
        .probe_tile_id(probe_tile_id), .probe_explosion(probe_explosion),
        .pos_x(pos_x), .pos_y(pos_y), .lives(lives), .is_invincible(is_invincible),
        .dead(dead), .busy(busy), .done(done)
    );

    player_engine #(.START_X(73), .INV_CYCLES(100)) u_dut73 (
        .clock(clock), .reset(reset), .player_reset(player_reset), .step(step73),
        .xmov(xmov73), .xdir(xdir73), .ymov(ymov73), .ydir(ydir73),
        .probe_x(probe_x73), .probe_y(probe_y73), .probe_valid(probe_valid73),
        .probe_tile_id(tile73), .probe_explosion(expl73),
        .pos_x(pos_x73), .pos_y(pos_y73), .lives(lives73), .is_invincible(inv73),
        .dead(dead73), .busy(busy73), .done(done73)
    );

    // The map answers by which corner of the current sprite is being probed.
    always_comb begin
        pcorner         = {probe_y != pos_y, probe_x != pos_x};
        probe_tile_id   = tile_map[{pcorner, 2'b00} +: 4];
        probe_explosion = expl_map[pcorner];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_step(input logic xm, input logic xd, input logic ym, input logic yd,
                           input logic dup);
        xmov = xm; xdir = xd; ymov = ym; ydir = yd;
        step = 1'b1;
        pv_mask = '0; done_n = 0; done_cnt = 0;
        @(posedge clock); #1;
        step = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            if (probe_valid) pv_mask[n] = 1'b1;
            if (done) begin done_cnt++; done_n = n; end
            if (n == 1) busy1 = busy;
            if (n == 3) begin tr_px = probe_x; tr_py = probe_y; end
            if (n == 7) begin br_px = probe_x; br_py = probe_y; end
            if (n == 9) px9 = pos_x;
            if (n == 10) begin px10 = pos_x; py10 = pos_y; end
            step = dup && (n == 4);
            @(posedge clock); #1;
        end
        step = 1'b0;
    endtask

    task automatic watch(input int n);
        pv_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (probe_valid) pv_cnt++;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            @(posedge clock); #1;
        end
    endtask

    task automatic pulse_player_reset();
        player_reset = 1'b1;
        @(posedge clock); #1;
        player_reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; player_reset = 1'b0; step = 1'b0;
        xmov = 1'b0; xdir = 1'b0; ymov = 1'b0; ydir = 1'b0;
        step73 = 1'b0; xmov73 = 1'b1; xdir73 = 1'b0; ymov73 = 1'b0; ydir73 = 1'b0;
        expl73 = 1'b0; tile73 = 4'd0;
        tile_map = '0; expl_map = '0;
        wait_cyc(3);
        check("rst_pos_x", pos_x, 72);
        check("rst_pos_y", pos_y, 112);
        check("rst_lives", lives, 3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_probe_valid", probe_valid, 0);
        check("rst_probe_x", probe_x, 0);
        check("rst_inv", is_invincible, 0);
        check("rst_dead", dead, 0);
        reset = 1'b0;
        wait_cyc(2);

        // Plain right move, with a second step pulsed mid-sequence that must be dropped.
        do_step(1, 1, 0, 0, 1);
        check("mv_busy_k1", busy1, 1);
        check("mv_probe_mask", pv_mask, 16'h00AA);
        check("mv_done_cycle", done_n, 10);
        check("mv_done_count", done_cnt, 1);
        check("mv_x_before_k9", px9, 72);
        check("mv_x_after_k9", px10, 74);
        check("mv_y", pos_y, 112);
        check("mv_tr_probe_x", tr_px, 87);
        check("mv_tr_probe_y", tr_py, 112);
        check("mv_br_probe_x", br_px, 87);
        check("mv_br_probe_y", br_py, 127);
        check("mv_busy_after", busy, 0);

        // Wall at TR blocks X only; Y moves down independently.
        tile_map = 16'h0030;
        do_step(1, 1, 1, 1, 0);
        check("blk_x_hold", px10, 74);
        check("blk_y_move", py10, 114);
        check("blk_done", done_cnt, 1);
        tile_map = '0;

        for (int i = 0; i < 100 && pos_x != 9'd232; i++) do_step(1, 1, 0, 0, 0);
        check("wall_reach_232", pos_x, 232);
        do_step(1, 1, 0, 0, 0);
        check("wall_hold_232", pos_x, 232);
        check("wall_done", done_cnt, 1);

        // x=73 cannot step left by 2 without crossing 72.
        step73 = 1'b1;
        @(posedge clock); #1;
        step73 = 1'b0;
        pv_cnt = 0; done_cnt = 0;
        for (int n = 1; n <= 12; n++) begin
            if (probe_valid73) pv_cnt++;
            if (done73) done_cnt++;
            if (n == 1) check("odd_tl_probe_x", probe_x73, 73);
            if (n == 5) check("odd_bl_probe_y", probe_y73, 127);
            @(posedge clock); #1;
        end
        check("odd_x_hold_73", pos_x73, 73);
        check("odd_y", pos_y73, 112);
        check("odd_probe_count", pv_cnt, 4);
        check("odd_done_count", done_cnt, 1);
        check("odd_lives", lives73, 3);
        check("odd_dead", dead73, 0);
        check("odd_busy", busy73, 0);
        check("odd_inv", inv73, 0);

        pulse_player_reset();
        check("prst_pos_x", pos_x, 72);
        check("prst_pos_y", pos_y, 112);
        check("prst_lives", lives, 3);

        expl_map = 4'hF;
        do_step(0, 0, 0, 0, 0);
        check("hit1_lives", lives, 2);
        check("hit1_inv", is_invincible, 1);
        do_step(0, 0, 0, 0, 0);
        check("hit2_inv_lives", lives, 2);
        // Timer loaded 100 at the first MOVE edge; 80 remain here.
        wait_cyc(79);
        check("inv_last_cycle", is_invincible, 1);
        wait_cyc(1);
        check("inv_expired", is_invincible, 0);
        do_step(0, 0, 0, 0, 0);
        check("hit3_lives", lives, 1);
        wait_cyc(100);
        do_step(0, 0, 0, 0, 0);
        check("hit4_lives", lives, 0);
        check("hit4_dead", dead, 1);
        do_step(1, 1, 0, 0, 0);
        check("dead_no_probe", pv_mask, 0);
        check("dead_no_done", done_cnt, 0);
        check("dead_pos_x", pos_x, 72);
        expl_map = '0;
        pulse_player_reset();
        check("revive_lives", lives, 3);
        check("revive_dead", dead, 0);
        check("revive_inv", is_invincible, 0);
        check("revive_pos_x", pos_x, 72);
        check("revive_pos_y", pos_y, 112);

        // Asynchronous reset in cycle k+5 aborts the sequence.
        xmov = 1'b1; xdir = 1'b1; ymov = 1'b0;
        step = 1'b1;
        @(posedge clock); #1;
        step = 1'b0;
        wait_cyc(4);
        check("abort_busy_k5", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy_now", busy, 0);
        check("abort_probe_valid", probe_valid, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        watch(12);
        check("abort_no_done", done_cnt, 0);
        check("abort_no_probe", pv_cnt, 0);
        check("abort_pos_x", pos_x, 72);
        check("abort_lives", lives, 3);

        // player_reset wins over a simultaneous step.
        player_reset = 1'b1; step = 1'b1;
        @(posedge clock); #1;
        player_reset = 1'b0; step = 1'b0;
        watch(12);
        check("prst_step_no_probe", pv_cnt, 0);
        check("prst_step_no_busy", busy_cnt, 0);
        check("prst_step_pos_x", pos_x, 72);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/player_engine.md
PLAYER_ENGINE -- requirements
Module: player_engine

Interface
REQ-001 Parameters SHALL be: COORD_W 9 coordinate width; START_X 72, START_Y 112 spawn position; MIN_X 72, MAX_X 232, MIN_Y 32, MAX_Y 192 sprite top-left bounds, inclusive; SPEED 2 pixels per step, 5 bits; SPRITE 16 sprite edge in pixels; LIVES_MAX 3; INV_CYCLES 100000000 invincibility length in clocks; EMPTY_TILE 0 walkable tile id.
REQ-002 Ports SHALL be, clock and reset first:
- clock, in, 1: system clock, 50 MHz.
- reset, in, 1: asynchronous, active-high.
- player_reset, in, 1: synchronous respawn.
- step, in, 1: one-cycle refresh pulse.
- xmov, xdir, ymov, ydir, in, 1 each: move requests; dir 1 = increasing coordinate.
- probe_x, probe_y, out, COORD_W each: corner pixel being queried.
- probe_valid, out, 1: query strobe.
- probe_tile_id, in, 4: map tile at the probe.
- probe_explosion, in, 1: explosion at the probe.
- pos_x, pos_y, out, COORD_W each: sprite top-left.
- lives, out, 2.
- is_invincible, out, 1.
- dead, out, 1.
- busy, out, 1.
- done, out, 1: one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, MOVE and DONE, plus a 2-bit corner index over TL, TR, BL, BR.
REQ-004 In IDLE, when step=1 and dead=0, the FSM SHALL go to ISSUE with corner=0 and set busy=1; a step during busy or while dead SHALL be ignored without being queued.
REQ-005 ISSUE SHALL assert probe_valid for exactly one cycle, with probe_x = pos_x + (SPRITE-1 if corner is TR/BR) and probe_y = pos_y + (SPRITE-1 if corner is BL/BR), then go to WAIT.
REQ-006 WAIT SHALL sample probe_tile_id and probe_explosion on its closing edge, set empty[corner] = (probe_tile_id==EMPTY_TILE), and OR probe_explosion into a hit flag; it SHALL then go to ISSUE with corner+1, or to MOVE after BR.
REQ-007 In MOVE, X SHALL change when xmov=1 and the leading corners are empty: TR&BR when xdir=1, TL&BL when xdir=0.
REQ-008 In MOVE, Y SHALL change when ymov=1 and the leading corners are empty: BL&BR when ydir=1, TL&TR when ydir=0; X and Y SHALL update independently in the same cycle.
REQ-009 An increase SHALL occur only if coord <= MAX-SPEED, and a decrease only if coord >= MIN+SPEED; otherwise that axis SHALL hold, with no partial move and no wrap.
REQ-010 If hit=1 and is_invincible=0 in MOVE, lives SHALL decrement exactly once per step, saturating at 0, and the invincibility counter SHALL load INV_CYCLES.
REQ-011 A hit while is_invincible=1 SHALL change neither lives nor the counter.
REQ-012 The invincibility counter SHALL decrement every clock while nonzero; is_invincible = (counter != 0).
REQ-013 dead SHALL equal (lives==0); once dead, position SHALL hold until player_reset.
REQ-014 DONE SHALL pulse done=1 for one cycle, clear busy and the hit flag, and return to IDLE.
REQ-015 Latency SHALL be 10 cycles: step sampled at edge k, probe_valid high in cycles k+1, k+3, k+5 and k+7, pos update at edge k+9, done high in cycle k+10.
REQ-016 player_reset=1 SHALL override all activity on its edge: pos to START, lives to LIVES_MAX, counter to 0, FSM to IDLE, busy=0, done=0; a step in the same cycle SHALL be dropped.

Reset
REQ-017 On reset=1, asynchronously: pos_x=START_X, pos_y=START_Y, lives=LIVES_MAX, invincibility counter=0, state=IDLE, corner=0, empty=0, hit=0, probe_valid=0, busy=0, done=0, probe_x=0, probe_y=0.
REQ-018 Reset asserted mid-sequence SHALL abort the sequence with no pos or lives change and no done pulse.

Structure
REQ-019 Shared package bomberman_pkg SHALL hold the FSM state encoding, corner index constants, EMPTY_TILE, and the playfield bound constants.
REQ-020 The invincibility timer SHALL be a sub-module inv_timer (load, count, active), sized $clog2(INV_CYCLES+1) bits.

Verification
REQ-021 Bench SHALL cover: after reset, step with xmov=1, xdir=1 and all tiles 0 -> pos_x 72→74 at edge k+9, done in cycle k+10, probe_valid exactly 4 pulses.
REQ-022 Bench SHALL cover: pos_x=232, step with xdir=1 -> pos_x stays 232; pos_x=73 with SPEED=2, xdir=0 -> stays 73.
REQ-023 Bench SHALL cover: TR tile id 3, step with xmov=1, xdir=1, ymov=1, ydir=1 -> X holds, Y 112→114.
REQ-024 Bench SHALL cover: probe_explosion=1 at all four corners, INV_CYCLES=100 -> lives 3→2 once; a second hit step within 100 cycles leaves 2; after counter expiry a hit gives 1.
REQ-025 Bench SHALL cover: three spaced hits -> lives 0, dead=1; further steps produce no probe_valid; player_reset -> lives 3, pos (72,112).
REQ-026 Bench SHALL cover: reset at cycle k+5 -> busy=0 immediately, no done, pos unchanged; player_reset together with step -> no sequence starts.
